// File: rtl/config_loader_if.sv
// config_loader_if: word-source handshake and latch-array drive bundle for config_loader.
interface config_loader_if #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 44,
    parameter int IDX_W     = 6
);
    logic                 io_start;
    logic                 io_abort;
    logic [WORD_W-1:0]    io_word_in;
    logic                 io_word_valid;
    logic                 io_word_ready;
    logic [WORD_W-1:0]    io_d_out;
    logic [NUM_WORDS-1:0] io_configs_en;
    logic [IDX_W-1:0]     io_word_idx;
    logic                 io_busy;
    logic                 io_done;

    modport master (
        output io_start, io_abort, io_word_in, io_word_valid,
        input  io_word_ready, io_d_out, io_configs_en, io_word_idx, io_busy, io_done
    );

    modport slave (
        input  io_start, io_abort, io_word_in, io_word_valid,
        output io_word_ready, io_d_out, io_configs_en, io_word_idx, io_busy, io_done
    );
endinterface

// File: rtl/config_loader.sv
// config_loader: streams NUM_WORDS config words into a latch array with glitch-free one-hot gate strobes.
module config_loader #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 44
) (
    input logic            clk,
    input logic            reset,
    config_loader_if.slave bus
);
    localparam int IDX_W = 6;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_WORDS - 1);
    localparam logic [NUM_WORDS-1:0] ONE = NUM_WORDS'(1);

    typedef enum logic [2:0] {IDLE, WAIT, SETUP, STROBE, HOLD, DONE} state_t;

    state_t               state, state_n;
    logic [IDX_W-1:0]     idx, idx_n;
    logic [WORD_W-1:0]    d, d_n;
    logic [NUM_WORDS-1:0] en, en_n;
    logic                 busy, busy_n, done, done_n;

    wire idle_like = (state == IDLE) || (state == DONE);

    // Outputs are registered from their next-state values so latch gates never glitch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            idx   <= '0;
            d     <= '0;
            en    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            d     <= d_n;
            en    <= en_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    always_comb begin
        state_n = bus.io_abort         ? IDLE :
                  idle_like            ? (bus.io_start ? WAIT : state) :
                  (state == WAIT)      ? (bus.io_word_valid ? SETUP : WAIT) :
                  (state == SETUP)     ? STROBE :
                  (state == STROBE)    ? HOLD :
                  (state == HOLD)      ? ((idx == LAST) ? DONE : WAIT) :
                                         IDLE;
    end

    always_comb begin
        idx_n  = (bus.io_abort || (idle_like && bus.io_start)) ? '0 :
                 (state == HOLD && idx != LAST)                ? idx + IDX_W'(1) :
                                                                 idx;
        d_n    = (state == WAIT && bus.io_word_valid && !bus.io_abort) ? bus.io_word_in : d;
        en_n   = (state_n == STROBE) ? ONE << idx_n : '0;
        busy_n = state_n inside {WAIT, SETUP, STROBE, HOLD};
        done_n = (state_n == DONE);
    end

    assign bus.io_word_ready = (state == WAIT);
    assign bus.io_d_out      = d;
    assign bus.io_configs_en = en;
    assign bus.io_word_idx   = idx;
    assign bus.io_busy       = busy;
    assign bus.io_done       = done;
endmodule

// File: tb/tb_config_loader.sv
// tb_config_loader: directed scenarios with a pulse scoreboard and per-cycle enable/data invariants.
module tb_config_loader;
    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 44;
    localparam int IDX_W     = 6;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [WORD_W-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int c0 = 0;
    exp_t q[$];
    exp_t e;
    logic [IDX_W-1:0] m_idx = '0;

    logic [NUM_WORDS-1:0] en_prev = '0;
    logic [WORD_W-1:0]    d_prev = '0;
    logic [WORD_W-1:0]    w_prev = '0;
    logic                 acc_prev = 1'b0;

    config_loader_if #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .IDX_W(IDX_W)) bus ();

    config_loader #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] onehot(input logic [IDX_W-1:0] i);
        return 64'd1 << i;
    endfunction

    // Invariants and scoreboard pops, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            en_prev  = '0;
            d_prev   = '0;
            w_prev   = '0;
            acc_prev = 1'b0;
        end else begin
            check("en_onehot0", 64'($countones(bus.io_configs_en) <= 1), 64'd1);
            check("en_no_repeat", 64'(bus.io_configs_en & en_prev), 64'd0);
            check("d_change_only_on_accept", 64'(bus.io_d_out), 64'(acc_prev ? w_prev : d_prev));
            if (bus.io_configs_en != '0) begin
                if (q.size() == 0) begin
                    check("sb_unexpected_pulse", 64'(bus.io_configs_en), 64'd0);
                end else begin
                    e = q.pop_front();
                    check("sb_en", 64'(bus.io_configs_en), onehot(e.idx));
                    check("sb_data", 64'(bus.io_d_out), 64'(e.data));
                end
            end
            en_prev  = bus.io_configs_en;
            d_prev   = bus.io_d_out;
            w_prev   = bus.io_word_in;
            acc_prev = bus.io_word_valid && bus.io_word_ready;
        end
    end

    task automatic wait_neg_ready(input string tag);
        int n = 0;
        @(negedge clk);
        while (!bus.io_word_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready_timeout"}, 64'(bus.io_word_ready), 64'd1);
    endtask

    task automatic send_word(input logic [WORD_W-1:0] w);
        bus.io_word_in    = w;
        bus.io_word_valid = 1'b1;
        wait_neg_ready("send");
        q.push_back(exp_t'({m_idx, w}));
        m_idx++;
        @(posedge clk);
        #1;
    endtask

    task automatic start_seq();
        bus.io_start = 1'b1;
        m_idx = '0;
        @(posedge clk);
        #1;
        bus.io_start = 1'b0;
        c0 = cyc;
    endtask

    task automatic wait_done(input string tag, input int exp_cycles);
        int n = 0;
        @(negedge clk);
        while (!bus.io_done && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_cycles"}, 64'(cyc - c0 + 1), 64'(exp_cycles));
        check({tag, "_busy_in_done"}, 64'(bus.io_busy), 64'd0);
        check({tag, "_sb_empty"}, 64'(q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_en"}, 64'(bus.io_configs_en), 64'd0);
        check({tag, "_idx"}, 64'(bus.io_word_idx), 64'd0);
        check({tag, "_busy"}, 64'(bus.io_busy), 64'd0);
        check({tag, "_done"}, 64'(bus.io_done), 64'd0);
        check({tag, "_ready"}, 64'(bus.io_word_ready), 64'd0);
    endtask

    initial begin
        bus.io_start      = 1'b0;
        bus.io_abort      = 1'b0;
        bus.io_word_in    = '0;
        bus.io_word_valid = 1'b0;
        #12;
        check_cleared("reset");
        check("reset_d", 64'(bus.io_d_out), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("idle_ready", 64'(bus.io_word_ready), 64'd0);

        // Full load with valid held high.
        start_seq();
        check("start_busy", 64'(bus.io_busy), 64'd1);
        check("start_ready", 64'(bus.io_word_ready), 64'd1);
        for (int k = 0; k < NUM_WORDS; k++) send_word(32'hA5A5_0000 + 32'(k));
        bus.io_word_valid = 1'b0;
        wait_done("full", NUM_WORDS * 4 + 1);
        repeat (3) @(posedge clk);
        #1;
        check("done_hold", 64'(bus.io_done), 64'd1);
        check("done_idx_last", 64'(bus.io_word_idx), 64'(NUM_WORDS - 1));

        // Restart from DONE with a 10-cycle source stall before word 5.
        start_seq();
        check("restart_done_clr", 64'(bus.io_done), 64'd0);
        check("restart_idx", 64'(bus.io_word_idx), 64'd0);
        for (int k = 0; k < 5; k++) send_word(32'h5A5A_0000 + 32'(k));
        bus.io_word_valid = 1'b0;
        wait_neg_ready("stall");
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            check("stall_ready", 64'(bus.io_word_ready), 64'd1);
            check("stall_en", 64'(bus.io_configs_en), 64'd0);
            check("stall_d", 64'(bus.io_d_out), 64'h5A5A_0004);
        end
        @(posedge clk);
        #1;
        for (int k = 5; k < NUM_WORDS; k++) send_word(32'h5A5A_0000 + 32'(k));
        bus.io_word_valid = 1'b0;
        wait_done("stall", NUM_WORDS * 4 + 1 + 10);

        // Abort during STROBE of word 20, then reload from bank 0.
        start_seq();
        for (int k = 0; k <= 20; k++) send_word(32'h3C3C_0000 + 32'(k));
        bus.io_word_valid = 1'b0;
        @(posedge clk);
        #1;
        check("abort_strobe_en", 64'(bus.io_configs_en), onehot(6'd20));
        bus.io_abort = 1'b1;
        @(posedge clk);
        #1;
        bus.io_abort = 1'b0;
        q.delete();
        check_cleared("abort");
        check("abort_d_kept", 64'(bus.io_d_out), 64'h3C3C_0014);
        start_seq();
        send_word(32'h7777_0000);
        send_word(32'h7777_0001);
        bus.io_word_valid = 1'b0;
        @(posedge clk);
        #1;
        check("reload_idx", 64'(bus.io_word_idx), 64'd1);
        check("reload_en", 64'(bus.io_configs_en), onehot(6'd1));
        bus.io_abort = 1'b1;
        @(posedge clk);
        #1;
        bus.io_abort = 1'b0;
        q.delete();

        // Asynchronous reset between edges while word 7 strobes.
        start_seq();
        for (int k = 0; k <= 7; k++) send_word(32'h1E1E_0000 + 32'(k));
        bus.io_word_valid = 1'b0;
        @(posedge clk);
        #1;
        check("pre_reset_en", 64'(bus.io_configs_en), onehot(6'd7));
        #2;
        reset = 1'b0;
        #1;
        check_cleared("async_reset");
        check("async_reset_d", 64'(bus.io_d_out), 64'd0);
        q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        start_seq();
        for (int k = 0; k < NUM_WORDS; k++) send_word(32'h0F0F_0000 + 32'(k));
        bus.io_word_valid = 1'b0;
        wait_done("after_reset", NUM_WORDS * 4 + 1);

        // Start while busy is ignored; start with abort aborts.
        start_seq();
        for (int k = 0; k <= 3; k++) send_word(32'h6B6B_0000 + 32'(k));
        bus.io_start = 1'b1;
        @(posedge clk);
        #1;
        bus.io_start = 1'b0;
        check("busy_start_busy", 64'(bus.io_busy), 64'd1);
        check("busy_start_idx", 64'(bus.io_word_idx), 64'd3);
        check("busy_start_en", 64'(bus.io_configs_en), onehot(6'd3));
        for (int k = 4; k <= 5; k++) send_word(32'h6B6B_0000 + 32'(k));
        bus.io_word_valid = 1'b0;
        bus.io_start = 1'b1;
        bus.io_abort = 1'b1;
        @(posedge clk);
        #1;
        bus.io_start = 1'b0;
        bus.io_abort = 1'b0;
        q.delete();
        check_cleared("start_abort");
        @(posedge clk);
        #1;
        check("start_abort_stays_idle", 64'(bus.io_busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 SHALL have parameter WORD_W, default 32, config word width.
REQ-002 SHALL have parameter NUM_WORDS, default 44, number of latch banks; index width IDX_W = 6.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port io_start  input  1  begin a load sequence.
REQ-006 SHALL have port io_abort  input  1  cancel the sequence in progress.
REQ-007 SHALL have port io_word_in  input  WORD_W  next config word from the source.
REQ-008 SHALL have port io_word_valid  input  1  io_word_in valid.
REQ-009 SHALL have port io_word_ready  output  1  loader accepts a word this cycle.
REQ-010 SHALL have port io_d_out  output  WORD_W  data bus to the config latch array.
REQ-011 SHALL have port io_configs_en  output  NUM_WORDS  one-hot latch gate enables.
REQ-012 SHALL have port io_word_idx  output  IDX_W  index of the bank being written.
REQ-013 SHALL have port io_busy  output  1  sequence in progress.
REQ-014 SHALL have port io_done  output  1  all NUM_WORDS banks written.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, SETUP, STROBE, HOLD, DONE.
REQ-016 SHALL drive io_d_out, io_configs_en, io_word_idx, io_busy and io_done from flops only (no combinational glitches on latch gates); io_word_ready SHALL equal (state==WAIT).
REQ-017 IDLE or DONE with io_start=1 -> WAIT, idx=0, io_done cleared; io_start in any other state SHALL be ignored.
REQ-018 WAIT: on io_word_valid&&io_word_ready (cycle T), capture io_word_in into io_d_out and -> SETUP; no valid -> stay in WAIT, outputs unchanged.
REQ-019 SETUP (T+1): io_d_out stable, io_configs_en all zero; -> STROBE.
REQ-020 STROBE (T+2): io_configs_en[idx]=1, all other bits 0; -> HOLD.
REQ-021 HOLD (T+3): io_configs_en all zero, io_d_out unchanged; then idx==NUM_WORDS-1 -> DONE, else idx+1 and -> WAIT.
REQ-022 Per-word throughput SHALL be 4 cycles minimum (WAIT, SETUP, STROBE, HOLD); io_d_out SHALL change only on an accepted word, never in SETUP, STROBE or HOLD.
REQ-023 At most one io_configs_en bit SHALL be high in any cycle; an enable bit SHALL never be high in consecutive cycles.
REQ-024 io_busy SHALL be 1 in WAIT, SETUP, STROBE and HOLD, and 0 in IDLE and DONE.
REQ-025 io_done SHALL be 1 in DONE and held until io_start or io_abort.
REQ-026 io_abort=1 in any state -> IDLE on next edge, io_configs_en=0, idx=0, io_done=0; io_d_out retains its value; banks already written are not revisited.
REQ-027 io_abort and io_start asserted together SHALL result in abort (IDLE).
REQ-028 idx SHALL never exceed NUM_WORDS-1; no wrap-around past the last bank.

Reset
REQ-029 reset low SHALL asynchronously force state=IDLE, io_d_out=0, io_configs_en=0, io_word_idx=0, io_busy=0, io_done=0, io_word_ready=0.
REQ-030 Reset deassertion SHALL take effect on the next rising clk edge; reset asserted mid-STROBE SHALL drop the active enable immediately, without waiting for clk.

Verification
REQ-031 Full load: start, then stream words 0xA5A50000+k with valid held high -> io_configs_en[k] pulses 1 cycle with io_d_out=0xA5A50000+k stable from 1 cycle before through 1 cycle after the pulse; io_done=1 after 44*4+1 cycles.
REQ-032 Source stall: valid low for 10 cycles before word 5 -> loader stays in WAIT, ready=1, io_configs_en=0, io_d_out keeps word 4 value.
REQ-033 Abort in STROBE of word 20: en[20] high one cycle then 0, busy=0, idx=0, done=0; a new start reloads from bank 0.
REQ-034 Async reset mid-sequence (word 7, STROBE) between clock edges -> all outputs 0 immediately; the next start runs normally.
REQ-035 io_start while busy (word 3) -> ignored, sequence continues; start plus abort in same cycle -> IDLE.
REQ-036 Assertion over all scenarios: popcount(io_configs_en)<=1 every cycle and no enable bit high in two consecutive cycles.
